// File: rtl/elevator_motion_controller.sv
// SCAN-scheduled elevator car controller: latches calls, steps the one-hot floor on a travel timer, dwells with the door open.
// Optional ELEVATOR_DOOR_HOLD_EN adds a doorHold input that keeps the door open while asserted.
module elevator_motion_controller #(
  parameter int NUM_FLOORS    = 6,
  parameter int TRAVEL_CYCLES = 50,
  parameter int DOOR_CYCLES   = 100
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [NUM_FLOORS-1:0] call,
  input  logic                  estop,
`ifdef ELEVATOR_DOOR_HOLD_EN
  input  logic                  doorHold,
`endif
  output logic [NUM_FLOORS-1:0] currentFloor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  Up,
  output logic                  Down,
  output logic                  moving,
  output logic                  doorOpen,
  output logic [NUM_FLOORS-1:0] served
);

  localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR_OPEN} state_t;

  state_t                state, stateNext;
  logic [CW-1:0]         cnt, cntNext;
  logic [NUM_FLOORS-1:0] floorNext, pendingNext, servedNext, clearMask, latchMask;
  logic [NUM_FLOORS-1:0] floorBelow, floorAbove, aheadCalls, behindCalls, stepFloor;
  logic                  upNext, movingNext, doorOpenNext, callHere, holdReq, atEnd;

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign holdReq = doorHold;
`else
  assign holdReq = 1'b0;
`endif

  assign Down = ~Up;

  // Subtracting one from a one-hot position yields every floor strictly below it
  assign floorBelow  = currentFloor - NUM_FLOORS'(1);
  assign floorAbove  = ~(floorBelow | currentFloor);
  assign aheadCalls  = Up ? (pending & floorAbove) : (pending & floorBelow);
  assign behindCalls = Up ? (pending & floorBelow) : (pending & floorAbove);
  assign callHere    = |(call & currentFloor);
  assign atEnd       = Up ? currentFloor[NUM_FLOORS-1] : currentFloor[0];
  assign stepFloor   = atEnd ? currentFloor :
                       (Up ? {currentFloor[NUM_FLOORS-2:0], 1'b0}
                           : {1'b0, currentFloor[NUM_FLOORS-1:1]});

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      currentFloor <= NUM_FLOORS'(1);
      pending      <= '0;
      Up           <= 1'b1;
      moving       <= 1'b0;
      doorOpen     <= 1'b0;
      served       <= '0;
    end else begin
      state        <= stateNext;
      cnt          <= cntNext;
      currentFloor <= floorNext;
      pending      <= pendingNext;
      Up           <= upNext;
      moving       <= movingNext;
      doorOpen     <= doorOpenNext;
      served       <= servedNext;
    end
  end

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    floorNext  = currentFloor;
    upNext     = Up;
    servedNext = '0;
    clearMask  = '0;
    latchMask  = (state == MOVE) ? call : (call & ~currentFloor);

    if (!estop) begin
      unique case (state)
        IDLE: begin
          if (callHere) begin
            stateNext  = DOOR_OPEN;
            cntNext    = DOOR_LOAD;
            servedNext = currentFloor;
          end else if (|aheadCalls) begin
            stateNext = MOVE;
            cntNext   = TRAVEL_LOAD;
          end else if (|behindCalls) begin
            upNext    = ~Up;
            stateNext = MOVE;
            cntNext   = TRAVEL_LOAD;
          end
        end
        MOVE: begin
          if (cnt != '0) begin
            cntNext = cnt - CW'(1);
          end else if (!(|aheadCalls) || atEnd) begin
            stateNext = IDLE;
          end else begin
            floorNext = stepFloor;
            // A call landing on the arrival edge is served rather than latched
            if (|((pending | call) & stepFloor)) begin
              clearMask  = stepFloor;
              servedNext = stepFloor;
              stateNext  = DOOR_OPEN;
              cntNext    = DOOR_LOAD;
            end else begin
              cntNext = TRAVEL_LOAD;
            end
          end
        end
        DOOR_OPEN: begin
          if (callHere || holdReq) begin
            cntNext = DOOR_LOAD;
            if (callHere) servedNext = currentFloor;
          end else if (cnt == '0) begin
            stateNext = IDLE;
          end else begin
            cntNext = cnt - CW'(1);
          end
        end
        default: stateNext = IDLE;
      endcase
    end

    if (floorNext[0])            upNext = 1'b1;
    if (floorNext[NUM_FLOORS-1]) upNext = 1'b0;

    pendingNext  = (pending | latchMask) & ~clearMask;
    movingNext   = (stateNext == MOVE) && !estop;
    doorOpenNext = (stateNext == DOOR_OPEN);
  end

endmodule

// File: tb/tb_elevator_motion_controller.sv
// Directed bench for elevator_motion_controller with TRAVEL_CYCLES=4, DOOR_CYCLES=6.
// Define ELEVATOR_DOOR_HOLD_EN to also exercise the doorHold input.
module tb_elevator_motion_controller;

  localparam int NF = 6;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [NF-1:0] call;
  logic          estop;
  logic          doorHold;
  logic [NF-1:0] currentFloor, pending, served;
  logic          Up, Down, moving, doorOpen;

  int vectors    = 0;
  int miscompares = 0;

  elevator_motion_controller #(
    .NUM_FLOORS(NF), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)
  ) dut (
    .Clock(Clock), .Reset(Reset), .call(call), .estop(estop),
`ifdef ELEVATOR_DOOR_HOLD_EN
    .doorHold(doorHold),
`endif
    .currentFloor(currentFloor), .pending(pending), .Up(Up), .Down(Down),
    .moving(moving), .doorOpen(doorOpen), .served(served)
  );

  always #5 Clock = ~Clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [NF-1:0] observed, input logic [NF-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NF-1:0] c, input logic e);
    call  = c;
    estop = e;
  endtask

  initial begin
    Reset = 1'b1; call = '0; estop = 1'b0; doorHold = 1'b0;
    tick(1);
    checkOutput("rst_floor",   currentFloor, 6'b000001);
    checkOutput("rst_pending", pending,      6'b000000);
    checkOutput("rst_up",      NF'(Up),      6'd1);
    checkOutput("rst_down",    NF'(Down),    6'd0);
    checkOutput("rst_moving",  NF'(moving),  6'd0);
    checkOutput("rst_door",    NF'(doorOpen),6'd0);
    checkOutput("rst_served",  served,       6'b000000);
    Reset = 1'b0;

    // Single call to floor 2
    applyStimulus(6'b000100, 1'b0);
    tick(1);
    checkOutput("t1_pending", pending, 6'b000100);
    checkOutput("t1_idle_mv", NF'(moving), 6'd0);
    applyStimulus(6'b000000, 1'b0);
    tick(1);
    checkOutput("t1_moving", NF'(moving), 6'd1);
    tick(3);
    checkOutput("t1_pre_step", currentFloor, 6'b000001);
    tick(1);
    checkOutput("t1_step1", currentFloor, 6'b000010);
    tick(4);
    checkOutput("t1_arrive", currentFloor, 6'b000100);
    checkOutput("t1_served", served, 6'b000100);
    checkOutput("t1_door", NF'(doorOpen), 6'd1);
    checkOutput("t1_clear", pending, 6'b000000);
    checkOutput("t1_arr_mv", NF'(moving), 6'd0);
    tick(5);
    checkOutput("t1_door_last", NF'(doorOpen), 6'd1);
    checkOutput("t1_served_off", served, 6'b000000);
    tick(1);
    checkOutput("t1_door_closed", NF'(doorOpen), 6'd0);

    // SCAN: continue up to 5, then reverse to 0
    applyStimulus(6'b100001, 1'b0);
    tick(1);
    checkOutput("t2_pending", pending, 6'b100001);
    applyStimulus(6'b000000, 1'b0);
    tick(1);
    checkOutput("t2_moving", NF'(moving), 6'd1);
    checkOutput("t2_up", NF'(Up), 6'd1);
    tick(12);
    checkOutput("t2_top", currentFloor, 6'b100000);
    checkOutput("t2_top_served", served, 6'b100000);
    checkOutput("t2_top_down", NF'(Down), 6'd1);
    checkOutput("t2_top_pending", pending, 6'b000001);
    tick(6);
    checkOutput("t2_idle_door", NF'(doorOpen), 6'd0);
    checkOutput("t2_idle_mv", NF'(moving), 6'd0);
    tick(1);
    checkOutput("t2_rev_moving", NF'(moving), 6'd1);
    checkOutput("t2_rev_down", NF'(Down), 6'd1);
    tick(20);
    checkOutput("t2_bottom", currentFloor, 6'b000001);
    checkOutput("t2_bot_served", served, 6'b000001);
    checkOutput("t2_bot_up", NF'(Up), 6'd1);
    checkOutput("t2_bot_pending", pending, 6'b000000);
    tick(6);

    // Travel to floor 3, then current-floor calls in IDLE and mid-dwell
    applyStimulus(6'b001000, 1'b0);
    tick(1);
    applyStimulus(6'b000000, 1'b0);
    tick(13);
    checkOutput("t3_arrive", currentFloor, 6'b001000);
    tick(6);
    checkOutput("t3_idle", NF'(doorOpen), 6'd0);
    applyStimulus(6'b001000, 1'b0);
    tick(1);
    checkOutput("t3_here_door", NF'(doorOpen), 6'd1);
    checkOutput("t3_here_served", served, 6'b001000);
    checkOutput("t3_here_nolatch", pending, 6'b000000);
    applyStimulus(6'b000000, 1'b0);
    tick(3);
    applyStimulus(6'b001000, 1'b0);
    tick(1);
    checkOutput("t3_redo_served", served, 6'b001000);
    applyStimulus(6'b000000, 1'b0);
    tick(5);
    checkOutput("t3_redo_door", NF'(doorOpen), 6'd1);
    tick(1);
    checkOutput("t3_redo_closed", NF'(doorOpen), 6'd0);

    // Estop mid-move, then arrival at 4 with a same-edge call
    applyStimulus(6'b010000, 1'b0);
    tick(1);
    applyStimulus(6'b000000, 1'b0);
    tick(1);
    checkOutput("t4_moving", NF'(moving), 6'd1);
    tick(1);
    applyStimulus(6'b000000, 1'b1);
    tick(1);
    checkOutput("t4_estop_mv", NF'(moving), 6'd0);
    applyStimulus(6'b000001, 1'b1);
    tick(1);
    checkOutput("t4_estop_latch", pending, 6'b010001);
    applyStimulus(6'b000000, 1'b1);
    tick(8);
    checkOutput("t4_frozen", currentFloor, 6'b001000);
    checkOutput("t4_frozen_mv", NF'(moving), 6'd0);
    applyStimulus(6'b000000, 1'b0);
    tick(1);
    checkOutput("t4_resume_mv", NF'(moving), 6'd1);
    tick(1);
    checkOutput("t4_not_yet", currentFloor, 6'b001000);
    applyStimulus(6'b010000, 1'b0);
    tick(1);
    checkOutput("t4_arrive", currentFloor, 6'b010000);
    checkOutput("t4_served", served, 6'b010000);
    checkOutput("t4_pending", pending, 6'b000001);
    checkOutput("t4_door", NF'(doorOpen), 6'd1);
    applyStimulus(6'b000000, 1'b0);
    tick(1);
    checkOutput("t4_single_pulse", served, 6'b000000);
    checkOutput("t4_pending_hold", pending, 6'b000001);
    tick(5);
    checkOutput("t4_closed", NF'(doorOpen), 6'd0);
    tick(1);
    checkOutput("t4_rev_mv", NF'(moving), 6'd1);
    checkOutput("t4_rev_down", NF'(Down), 6'd1);
    tick(2);

    // Reset mid-move
    Reset = 1'b1;
    tick(1);
    checkOutput("t5_floor",   currentFloor, 6'b000001);
    checkOutput("t5_pending", pending,      6'b000000);
    checkOutput("t5_up",      NF'(Up),      6'd1);
    checkOutput("t5_moving",  NF'(moving),  6'd0);
    checkOutput("t5_door",    NF'(doorOpen),6'd0);
    Reset = 1'b0;
    tick(1);

`ifdef ELEVATOR_DOOR_HOLD_EN
    applyStimulus(6'b000001, 1'b0);
    tick(1);
    checkOutput("t6_door", NF'(doorOpen), 6'd1);
    applyStimulus(6'b000000, 1'b0);
    doorHold = 1'b1;
    tick(20);
    checkOutput("t6_held", NF'(doorOpen), 6'd1);
    doorHold = 1'b0;
    tick(5);
    checkOutput("t6_tail", NF'(doorOpen), 6'd1);
    tick(1);
    checkOutput("t6_closed", NF'(doorOpen), 6'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/elevator_motion_controller.md
# elevator_motion_controller

Sequences car movement for the elevator. Latches floor calls, schedules travel with a SCAN policy (keep direction while calls lie ahead, otherwise reverse), steps the one-hot floor position on a travel timer, and holds the door open on a dwell timer. Served calls are cleared. Sits between the call-button/switch inputs and the floor/direction display logic, and is the sole owner of `currentFloor`.

## Interface
- `NUM_FLOORS`, 6: number of floors; one-hot width of floor vectors; must be ≥ 2
- `TRAVEL_CYCLES`, 50: clock cycles per one-floor move; must be ≥ 1
- `DOOR_CYCLES`, 100: door dwell in clock cycles; must be ≥ 1

Ports:
- `Clock`  in  1  single system clock; all logic on posedge
- `Reset`  in  1  synchronous, active-high; one clock, one synchronous active-high reset (decided)
- `call`  in  NUM_FLOORS  per-floor call request, level or pulse, sampled every posedge
- `estop`  in  1  emergency stop; freezes motion and timers while high
- `currentFloor`  out  NUM_FLOORS  one-hot car position; reset `{0..01}` (floor 0)
- `pending`  out  NUM_FLOORS  latched outstanding calls; reset 0
- `Up`  out  1  travel direction up; reset 1
- `Down`  out  1  always `~Up`; reset 0
- `moving`  out  1  high in MOVE while `estop` low; reset 0
- `doorOpen`  out  1  high in DOOR_OPEN; reset 0
- `served`  out  NUM_FLOORS  one-cycle pulse on the floor whose call was just honoured; reset 0

## Operation
- States: IDLE (reset), MOVE, DOOR_OPEN. All outputs registered.
- "Ahead" means `pending` bits strictly above `currentFloor` when Up, strictly below when Down. "Behind" is the opposite side.
- Latching: `pending[i] <= (pending[i] | call[i]) & ~clear[i]`. Clear wins over a simultaneous call on the same floor.
- Current-floor call:
  - A call on the current floor is never latched while in IDLE or DOOR_OPEN.
  - In IDLE it causes IDLE→DOOR_OPEN and pulses `served` for that floor.
  - In DOOR_OPEN it reloads the dwell timer and pulses `served`.
- IDLE:
  - If calls lie ahead → MOVE.
  - Else if calls lie behind → flip `Up`/`Down` and → MOVE on the same edge.
  - Else remain in IDLE.
  - Priority: current-floor call > ahead > behind.
- MOVE:
  - Travel counter loads `TRAVEL_CYCLES-1` on entry and decrements each cycle.
  - At 0, `currentFloor` shifts one position in the current direction.
  - If the new floor is pending: clear it, pulse `served`, and → DOOR_OPEN on that edge.
  - Otherwise reload the counter and stay in MOVE.
- DOOR_OPEN:
  - Dwell counter loads `DOOR_CYCLES-1` and decrements.
  - At 0 → IDLE; the next scheduling decision is made in IDLE.
- End floors:
  - At floor 0, `Up` is forced to 1; at the top floor, `Up` is forced to 0.
  - The shift never wraps, and `currentFloor` is always exactly one-hot.
- `estop`:
  - While high: state, counters and `currentFloor` are frozen, and `moving` is 0.
  - In DOOR_OPEN the door stays open.
  - Calls continue to latch.
  - On release, counting resumes from the frozen value.
- Reset mid-operation: every register returns to its reset value on the next posedge, and pending calls are discarded.
- Counter width: `$clog2(max(TRAVEL_CYCLES, DOOR_CYCLES))`, minimum 1 bit.

## Timing
- Call to `pending` visible: 1 cycle.
- IDLE with a call ahead → `moving`=1 on the next edge.
- Floor step: exactly `TRAVEL_CYCLES` cycles after MOVE entry or after the previous step (excluding `estop` cycles).
- Arrival: `currentFloor` update, `served` pulse, `doorOpen`=1 and the `pending` clear all occur on the same edge.
- Door open for exactly `DOOR_CYCLES` cycles, then IDLE for at least 1 cycle before MOVE.
- IDLE current-floor call: `doorOpen` and `served` assert on the next edge.

## Configuration
- `ELEVATOR_DOOR_HOLD_EN` defined:
  - Adds input port `doorHold` (1 bit).
  - While `doorHold` is high in DOOR_OPEN, the dwell counter reloads every cycle, so the door stays open until `DOOR_CYCLES` cycles after release.
- Undefined: the port is absent and the dwell is fixed.

## Test plan
Bench parameters: `TRAVEL_CYCLES`=4, `DOOR_CYCLES`=6.
- Reset, then `call`=`000100` for 1 cycle → MOVE Up; `currentFloor` `000010` after 4 cycles and `000100` after 8 cycles; `served`=`000100` pulse; `doorOpen` high for 6 cycles, then IDLE.
- At floor 2 Up, `pending`=`100001` → continues Up to floor 5 and serves it; at IDLE reverses (`Down`=1) and travels to floor 0, serving it.
- IDLE at floor 3 with `call`=`001000` → `doorOpen` and `served`=`001000` next edge; a repeat call mid-dwell restarts the 6-cycle dwell.
- `estop` high for 10 cycles mid-MOVE → `currentFloor` and counter frozen, `moving`=0, a new call still latches; after release the step lands 4 cycles minus the already-elapsed count later.
- Arrival at floor 4 with `call[4]`=1 on the same edge → `pending[4]`=0 and a single `served` pulse. Reset asserted mid-MOVE → all outputs at reset values next edge.
- With `ELEVATOR_DOOR_HOLD_EN` defined: `doorHold` held for 20 cycles → `doorOpen` stays high until 6 cycles after release.
